// File: rtl/adc_pkg.sv
// Shared types for the ADC sample reader: reader FSM states and default sample width.
package adc_pkg;

    localparam int COUNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        CONV
    } reader_state_e;

endpackage

// File: rtl/adc_sample_reader_if.sv
// ADC controller handshake plus the sample stream toward the consumer.
// master = reader side, slave = ADC controller / consumer side.
interface adc_sample_reader_if
    import adc_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEF
);
    logic               adc_restart;
    logic               adc_busy;
    logic               adc_valid;
    logic [COUNT_W-1:0] adc_count;
    logic [COUNT_W-1:0] m_data;
    logic               m_valid;
    logic               m_ready;

    modport master (
        output adc_restart, m_data, m_valid,
        input  adc_busy, adc_valid, adc_count, m_ready
    );

    modport slave (
        input  adc_restart, m_data, m_valid,
        output adc_busy, adc_valid, adc_count, m_ready
    );
endinterface

// File: rtl/adc_sample_reader_fifo.sv
// sample_fifo: small power-of-two sample buffer with occupancy count.
// The output holds the last popped value while empty.
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic [W-1:0]  last;
    logic          do_pop;
    logic          do_push;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot being written, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign level   = cnt;
    assign dout    = empty ? last : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            last   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last   <= mem[rd_ptr];
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/adc_sample_reader.sv
// Host-side initiator for the single-slope ADC: requests conversions, buffers counts.
// Optional watchdog built when ADC_TIMEOUT_EN is defined.
module adc_sample_reader
    import adc_pkg::*;
#(
    parameter int COUNT_W     = COUNT_W_DEF,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 300
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      trig,
    input  logic                      clr_flags,
    adc_sample_reader_if.master       bus,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic                      timeout
);
    reader_state_e state;
    reader_state_e state_n;
    logic          restart_q;
    logic          capture;
    logic          full;
    logic          empty;
    logic          drop;
    logic          expire;
    logic          hold;

    assign capture         = (state == CONV) && bus.adc_valid;
    assign drop            = capture && full && !bus.m_ready;
    assign bus.m_valid     = !empty;
    assign bus.adc_restart = restart_q;

    sample_fifo #(
        .DEPTH (DEPTH),
        .W     (COUNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .pop   (bus.m_ready),
        .din   (bus.adc_count),
        .dout  (bus.m_data),
        .full  (full),
        .empty (empty),
        .level (level)
    );

`ifdef ADC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] wd_cnt;

    // A valid arriving on the last allowed cycle still wins over the watchdog.
    assign expire = ((state == REQ) || ((state == CONV) && !bus.adc_valid))
                    && (wd_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt  <= '0;
            hold    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            hold <= expire;
            if ((state_n != state) || (state == IDLE)) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (expire) begin
                timeout <= 1'b1;
            end else if (clr_flags) begin
                timeout <= 1'b0;
            end
        end
    end
`else
    assign expire  = 1'b0;
    assign hold    = (TIMEOUT_CYC < 0);
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (trig || (en && !hold)) begin
                    state_n = REQ;
                end
            end
            REQ: begin
                if (expire) begin
                    state_n = IDLE;
                end else if (bus.adc_busy) begin
                    state_n = CONV;
                end
            end
            CONV: begin
                if (capture) begin
                    state_n = en ? REQ : IDLE;
                end else if (expire) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            restart_q <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            // Never request while the controller still reports a stale busy.
            restart_q <= (state_n == REQ) && !bus.adc_busy;
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_adc_sample_reader.sv
// Bench for adc_sample_reader: ADC controller model, queue reference model,
// table-driven single shots, hand-written corner sequences and random traffic.
module tb_adc_sample_reader;
    import adc_pkg::*;

    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       trig;
    logic       clr_flags;
    logic [2:0] level;
    logic       overflow;
    logic       timeout;

    adc_sample_reader_if #(.COUNT_W(W)) bus ();

    adc_sample_reader #(
        .COUNT_W     (W),
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (300)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .trig      (trig),
        .clr_flags (clr_flags),
        .bus       (bus),
        .level     (level),
        .overflow  (overflow),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ADC controller model: busy one cycle after restart, valid after k counts
    int         k_cyc = 3;
    bit         hang = 0;
    bit         mdl_rst = 0;
    logic [7:0] vq[$];
    int         strobes = 0;
    int         bursts = 0;
    bit         seen = 0;
    bit         bsy = 0;
    bit         dead = 0;
    bit         live = 0;
    int         ctr = 0;
    logic [7:0] cur = 0;

    always @(negedge clk) seen = bus.adc_restart;
    always @(posedge bus.adc_restart) bursts++;
    always @(posedge rst) dead = bsy;

    initial begin
        bus.adc_busy  = 1'b0;
        bus.adc_valid = 1'b0;
        bus.adc_count = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.adc_valid = 1'b0;
            live = 0;
            if (mdl_rst) begin
                bsy = 0;
                dead = 0;
                bus.adc_busy = 1'b0;
            end else if (bsy) begin
                if (!hang && ctr == 0) begin
                    bus.adc_valid = 1'b1;
                    bus.adc_count = cur;
                    bus.adc_busy  = 1'b0;
                    bsy = 0;
                    if (!dead) begin
                        strobes++;
                        live = 1;
                    end
                    dead = 0;
                end else begin
                    ctr--;
                end
            end else if (seen) begin
                bsy = 1;
                bus.adc_busy = 1'b1;
                ctr = k_cyc;
                cur = (vq.size() > 0) ? vq.pop_front() : 8'($urandom);
            end
        end
    end

    // Reference: a DEPTH-entry queue fed by every live conversion result
    logic [7:0] rq[$];
    logic [7:0] got[$];
    logic [7:0] rlast = 0;
    bit         rovf = 0;
    bit         sb_on = 0;
    int         maxlvl = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rq.delete();
            rlast = 0;
            rovf  = 0;
        end else begin
            if (rq.size() > 0 && bus.m_ready) begin
                rlast = rq.pop_front();
                got.push_back(rlast);
            end
            if (bus.adc_valid && live) begin
                if (rq.size() < DEPTH) rq.push_back(bus.adc_count);
                else rovf = 1;
            end else if (clr_flags) begin
                rovf = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (sb_on) begin
            chk("sb_m_valid", bus.m_valid, rq.size() > 0);
            chk("sb_level", level, rq.size());
            chk("sb_m_data", bus.m_data, (rq.size() > 0) ? rq[0] : rlast);
            chk("sb_overflow", overflow, rovf);
        end
        if (level > maxlvl) maxlvl = level;
    end

    task automatic wait_strobes(input int target, input int budget);
        while (strobes < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (strobes < target) begin
            tests++;
            fails++;
            $display("FAIL wait_strobes: got %0d expected %0d", strobes, target);
        end
    endtask

    task automatic pulse_trig();
        @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        chk("restart_latency", bus.adc_restart, 1'b1);
    endtask

    typedef struct {
        logic [7:0] val;
        int         k;
        logic [7:0] exp_data;
        int         exp_level;
    } vec_t;

    vec_t tbl[4];
    int   base;
    int   b0;

    initial begin
        tbl[0] = '{8'h2A, 3,  8'h2A, 1};
        tbl[1] = '{8'h00, 1,  8'h00, 1};
        tbl[2] = '{8'hFF, 8,  8'hFF, 1};
        tbl[3] = '{8'h80, 20, 8'h80, 1};

        rst = 1'b1;
        en = 1'b0;
        trig = 1'b0;
        clr_flags = 1'b0;
        bus.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_restart", bus.adc_restart, 1'b0);
        chk("rst_m_valid", bus.m_valid, 1'b0);
        chk("rst_m_data", bus.m_data, 8'h00);
        chk("rst_level", level, 3'd0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        rst = 1'b0;
        sb_on = 1;

        // single-shot conversions from the vector table
        for (int i = 0; i < 4; i++) begin
            vq.push_back(tbl[i].val);
            k_cyc = tbl[i].k;
            b0 = bursts;
            base = strobes;
            pulse_trig();
            wait_strobes(base + 1, 200);
            chk("t1_valid_cycle", bus.m_valid, 1'b0);
            @(negedge clk);
            chk("t1_m_valid", bus.m_valid, 1'b1);
            chk("t1_m_data", bus.m_data, tbl[i].exp_data);
            chk("t1_level", level, tbl[i].exp_level);
            repeat (6) @(negedge clk);
            chk("t1_bursts", bursts - b0, 1);
            chk("t1_idle", bus.adc_restart, 1'b0);
            bus.m_ready = 1'b1;
            @(negedge clk);
            bus.m_ready = 1'b0;
        end

        // free-run with consumer ready: three back-to-back samples
        got.delete();
        maxlvl = 0;
        vq = '{8'd5, 8'd6, 8'd7};
        k_cyc = 2;
        bus.m_ready = 1'b1;
        base = strobes;
        @(negedge clk);
        en = 1'b1;
        wait_strobes(base + 2, 200);
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        wait_strobes(base + 3, 200);
        repeat (20) @(negedge clk);
        chk("t2_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("t2_s0", got[0], 8'd5);
            chk("t2_s1", got[1], 8'd6);
            chk("t2_s2", got[2], 8'd7);
        end
        chk("t2_maxlvl_le1", maxlvl <= 1, 1'b1);
        chk("t2_overflow", overflow, 1'b0);
        chk("t2_stopped", strobes, base + 3);
        bus.m_ready = 1'b0;

        // free-run into a stalled consumer: DEPTH+1 conversions
        vq = '{8'd11, 8'd12, 8'd13, 8'd14, 8'd15};
        base = strobes;
        @(negedge clk);
        en = 1'b1;
        wait_strobes(base + 4, 300);
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        wait_strobes(base + 5, 200);
        repeat (6) @(negedge clk);
        chk("t3_level", level, DEPTH);
        chk("t3_overflow", overflow, 1'b1);
        chk("t3_head", bus.m_data, 8'd11);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        chk("t3_clr", overflow, 1'b0);

        // full FIFO, capture and pop on the same edge
        vq = '{8'd16};
        k_cyc = 3;
        pulse_trig();
        wait_strobes(base + 6, 200);
        bus.m_ready = 1'b1;
        @(negedge clk);
        bus.m_ready = 1'b0;
        chk("t4_level", level, DEPTH);
        chk("t4_head", bus.m_data, 8'd12);
        chk("t4_no_ovf", overflow, 1'b0);
        got.delete();
        bus.m_ready = 1'b1;
        repeat (6) @(negedge clk);
        bus.m_ready = 1'b0;
        chk("t4_drain_n", got.size(), 4);
        if (got.size() == 4) begin
            chk("t4_d0", got[0], 8'd12);
            chk("t4_d1", got[1], 8'd13);
            chk("t4_d2", got[2], 8'd14);
            chk("t4_d3", got[3], 8'd16);
        end

        // reset in the middle of a conversion
        vq = '{8'h33};
        k_cyc = 1;
        base = strobes;
        pulse_trig();
        wait_strobes(base + 1, 200);
        repeat (3) @(negedge clk);
        chk("t5_pre_level", level, 3'd1);
        vq = '{8'h44};
        k_cyc = 40;
        pulse_trig();
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_restart", bus.adc_restart, 1'b0);
        chk("t5_m_valid", bus.m_valid, 1'b0);
        chk("t5_m_data", bus.m_data, 8'h00);
        chk("t5_level", level, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("t5_no_push", level, 3'd0);
        chk("t5_m_valid_late", bus.m_valid, 1'b0);

`ifdef ADC_TIMEOUT_EN
        // controller never finishes: watchdog returns the reader to IDLE
        hang = 1;
        k_cyc = 2;
        pulse_trig();
        for (int i = 0; i < 700 && !timeout; i++) @(negedge clk);
        chk("t6_timeout", timeout, 1'b1);
        chk("t6_level", level, 3'd0);
        b0 = bursts;
        repeat (10) @(negedge clk);
        chk("t6_idle", bursts - b0, 0);
        mdl_rst = 1;
        hang = 0;
        repeat (2) @(negedge clk);
        mdl_rst = 0;
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        chk("t6_clr", timeout, 1'b0);
`else
        chk("t6_tied", timeout, 1'b0);
`endif

        // randomized traffic against the queue model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 31) == 0) en = ~en;
            trig        = ($urandom_range(0, 7) == 0);
            bus.m_ready = $urandom_range(0, 1);
            clr_flags   = ($urandom_range(0, 15) == 0);
            k_cyc       = $urandom_range(1, 5);
        end
        en = 1'b0;
        trig = 1'b0;
        clr_flags = 1'b0;
        repeat (20) @(negedge clk);
        bus.m_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("end_empty", bus.m_valid, 1'b0);
        chk("end_timeout", timeout, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
